// File: rtl/addr_mgmt.sv
// Packet buffer address manager: free-slot bitmap, write/read slot FSMs and an in-order pending FIFO.
// Optional drop statistics counter enabled by defining ADDR_MGMT_STAT_EN.
module addr_mgmt #(
  parameter int SLOT_AW = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_pkt_req,
  output logic               out_pkt_ack,
  output logic               out_pkt_drop,
  input  logic               in_data_ctrl_data_wr,
  input  logic [1:0]         in_data_ctrl_tag,
  output logic [10:0]        addr2data_waddr,
  output logic               addr2data_waddr_wr,
  input  logic               in_rd_req,
  output logic [10:0]        addr2data_raddr,
  output logic               addr2data_raddr_wr,
  input  logic               in_data_cache_valid_wr,
  output logic [SLOT_AW:0]   out_free_cnt,
  output logic [SLOT_AW:0]   out_queue_cnt
`ifdef ADDR_MGMT_STAT_EN
  ,
  output logic [15:0]        out_drop_cnt
`endif
);

  localparam int NSLOT   = 1 << SLOT_AW;
  localparam int SLOT_SH = 11 - SLOT_AW;
  localparam logic [SLOT_AW:0] CNT_FULL = (SLOT_AW+1)'(NSLOT);
  localparam logic [NSLOT-1:0] ONE_HOT0 = NSLOT'(1);

  typedef enum logic {W_IDLE, W_FILL} w_state_t;
  typedef enum logic {R_IDLE, R_BUSY} r_state_t;

  w_state_t           w_state;
  r_state_t           r_state;
  logic [NSLOT-1:0]   free_map;
  logic [NSLOT-1:0]   clr_mask;
  logic [NSLOT-1:0]   set_mask;
  logic [SLOT_AW-1:0] alloc_idx;
  logic [SLOT_AW-1:0] w_slot;
  logic [SLOT_AW-1:0] r_slot;
  logic [SLOT_AW-1:0] wptr;
  logic [SLOT_AW-1:0] rptr;
  logic [SLOT_AW-1:0] fifo_mem [NSLOT];
  logic               any_free;
  logic               fifo_nempty;
  logic               do_alloc;
  logic               do_drop;
  logic               do_push;
  logic               do_pop;
  logic               do_rel;

  function automatic logic [10:0] slot_base(input logic [SLOT_AW-1:0] s);
    return {s, {SLOT_SH{1'b0}}};
  endfunction

`ifdef ADDR_MGMT_STAT_EN
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction
`endif

  // Lowest-index free slot wins
  always_comb begin
    alloc_idx = '0;
    for (int i = NSLOT - 1; i >= 0; i--) begin
      if (free_map[i]) alloc_idx = SLOT_AW'(i);
    end
  end

  assign any_free    = |free_map;
  assign fifo_nempty = (out_queue_cnt != '0);
  assign do_alloc    = (w_state == W_IDLE) && in_pkt_req && any_free;
  assign do_drop     = (w_state == W_IDLE) && in_pkt_req && !any_free;
  assign do_push     = (w_state == W_FILL) && in_data_ctrl_data_wr && (in_data_ctrl_tag == 2'b10);
  assign do_pop      = (r_state == R_IDLE) && in_rd_req && fifo_nempty;
  assign do_rel      = (r_state == R_BUSY) && in_data_cache_valid_wr;
  assign clr_mask    = do_alloc ? (ONE_HOT0 << alloc_idx) : '0;
  assign set_mask    = do_rel   ? (ONE_HOT0 << r_slot)    : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_state            <= W_IDLE;
      w_slot             <= '0;
      out_pkt_ack        <= 1'b0;
      out_pkt_drop       <= 1'b0;
      addr2data_waddr    <= '0;
      addr2data_waddr_wr <= 1'b0;
    end else begin
      out_pkt_ack        <= 1'b0;
      out_pkt_drop       <= 1'b0;
      addr2data_waddr_wr <= 1'b0;
      if (w_state == W_IDLE) begin
        if (do_alloc) begin
          w_slot             <= alloc_idx;
          out_pkt_ack        <= 1'b1;
          addr2data_waddr_wr <= 1'b1;
          addr2data_waddr    <= slot_base(alloc_idx);
          w_state            <= W_FILL;
        end else if (do_drop) begin
          out_pkt_drop <= 1'b1;
        end
      end else if (do_push) begin
        w_state <= W_IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state            <= R_IDLE;
      r_slot             <= '0;
      addr2data_raddr    <= '0;
      addr2data_raddr_wr <= 1'b0;
    end else begin
      addr2data_raddr_wr <= 1'b0;
      if (r_state == R_IDLE) begin
        if (do_pop) begin
          r_slot             <= fifo_mem[rptr];
          addr2data_raddr    <= slot_base(fifo_mem[rptr]);
          addr2data_raddr_wr <= 1'b1;
          r_state            <= R_BUSY;
        end
      end else if (do_rel) begin
        r_state <= R_IDLE;
      end
    end
  end

  // Allocation sees the pre-release bitmap; a release and an allocation never target the same slot
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      free_map      <= '1;
      out_free_cnt  <= CNT_FULL;
      out_queue_cnt <= '0;
      wptr          <= '0;
      rptr          <= '0;
    end else begin
      free_map <= (free_map & ~clr_mask) | set_mask;
      case ({do_alloc, do_rel})
        2'b10:   out_free_cnt <= out_free_cnt - 1'b1;
        2'b01:   out_free_cnt <= out_free_cnt + 1'b1;
        default: out_free_cnt <= out_free_cnt;
      endcase
      case ({do_push, do_pop})
        2'b10:   out_queue_cnt <= out_queue_cnt + 1'b1;
        2'b01:   out_queue_cnt <= out_queue_cnt - 1'b1;
        default: out_queue_cnt <= out_queue_cnt;
      endcase
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) fifo_mem[wptr] <= w_slot;
  end

`ifdef ADDR_MGMT_STAT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_drop_cnt <= '0;
    end else if (do_drop) begin
      out_drop_cnt <= sat_inc16(out_drop_cnt);
    end
  end
`endif

endmodule

// File: tb/tb_addr_mgmt.sv
// Directed bench for addr_mgmt: vector table for single/back-to-back packets plus
// hand-written sequences for full/drop, release races, out-of-order frees and reset.
module tb_addr_mgmt;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req;
  logic        ack;
  logic        drop;
  logic        wr;
  logic [1:0]  tag;
  logic [10:0] waddr;
  logic        wwr;
  logic        rd;
  logic [10:0] raddr;
  logic        rwr;
  logic        vwr;
  logic [4:0]  fcnt;
  logic [4:0]  qcnt;
`ifdef ADDR_MGMT_STAT_EN
  logic [15:0] dcnt;
`endif

  int n_chk  = 0;
  int n_fail = 0;
  int exp_free;
  int exp_q;

  always #5 clk = ~clk;

  addr_mgmt #(.SLOT_AW(4)) dut (
    .clk                    (clk),
    .rst_n                  (rst_n),
    .in_pkt_req             (req),
    .out_pkt_ack            (ack),
    .out_pkt_drop           (drop),
    .in_data_ctrl_data_wr   (wr),
    .in_data_ctrl_tag       (tag),
    .addr2data_waddr        (waddr),
    .addr2data_waddr_wr     (wwr),
    .in_rd_req              (rd),
    .addr2data_raddr        (raddr),
    .addr2data_raddr_wr     (rwr),
    .in_data_cache_valid_wr (vwr),
    .out_free_cnt           (fcnt),
    .out_queue_cnt          (qcnt)
`ifdef ADDR_MGMT_STAT_EN
    ,
    .out_drop_cnt           (dcnt)
`endif
  );

  typedef struct {
    logic        req;
    logic        wr;
    logic [1:0]  tag;
    logic        rd;
    logic        vwr;
    logic        ack;
    logic        drop;
    logic        wwr;
    logic [10:0] waddr;
    logic        rwr;
    logic [10:0] raddr;
    logic [4:0]  fcnt;
    logic [4:0]  qcnt;
  } vec_t;

  vec_t vecs[$];

  task automatic add_v(input logic i_req, input logic i_wr, input logic [1:0] i_tag,
                       input logic i_rd, input logic i_vwr, input logic e_ack,
                       input logic e_drop, input logic e_wwr, input logic [10:0] e_waddr,
                       input logic e_rwr, input logic [10:0] e_raddr,
                       input logic [4:0] e_fcnt, input logic [4:0] e_qcnt);
    vec_t v;
    v.req = i_req; v.wr = i_wr; v.tag = i_tag; v.rd = i_rd; v.vwr = i_vwr;
    v.ack = e_ack; v.drop = e_drop; v.wwr = e_wwr; v.waddr = e_waddr;
    v.rwr = e_rwr; v.raddr = e_raddr; v.fcnt = e_fcnt; v.qcnt = e_qcnt;
    vecs.push_back(v);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic idle_inputs;
    req = 1'b0; wr = 1'b0; tag = 2'b00; rd = 1'b0; vwr = 1'b0;
  endtask

  // One single-beat packet: request, expect the given slot, then the EOP beat
  task automatic alloc(input int slot);
    req = 1'b1;
    tick();
    req = 1'b0;
    exp_free--;
    chk($sformatf("alloc%0d ack", slot), ack, 1);
    chk($sformatf("alloc%0d waddr_wr", slot), wwr, 1);
    chk($sformatf("alloc%0d waddr", slot), waddr, slot << 7);
    chk($sformatf("alloc%0d free_cnt", slot), fcnt, exp_free);
    wr = 1'b1; tag = 2'b10;
    tick();
    wr = 1'b0; tag = 2'b00;
    exp_q++;
    chk($sformatf("eop%0d queue_cnt", slot), qcnt, exp_q);
  endtask

  // Pop the head packet, expect the given slot, then report end of read
  task automatic rd_rel(input int slot);
    rd = 1'b1;
    tick();
    rd = 1'b0;
    exp_q--;
    chk($sformatf("read%0d raddr_wr", slot), rwr, 1);
    chk($sformatf("read%0d raddr", slot), raddr, slot << 7);
    chk($sformatf("read%0d queue_cnt", slot), qcnt, exp_q);
    vwr = 1'b1;
    tick();
    vwr = 1'b0;
    exp_free++;
    chk($sformatf("rel%0d free_cnt", slot), fcnt, exp_free);
  endtask

  task automatic chk_reset_outputs(input string nm);
    chk({nm, " ack"}, ack, 0);
    chk({nm, " drop"}, drop, 0);
    chk({nm, " waddr_wr"}, wwr, 0);
    chk({nm, " waddr"}, waddr, 0);
    chk({nm, " raddr_wr"}, rwr, 0);
    chk({nm, " raddr"}, raddr, 0);
    chk({nm, " free_cnt"}, fcnt, 16);
    chk({nm, " queue_cnt"}, qcnt, 0);
`ifdef ADDR_MGMT_STAT_EN
    chk({nm, " drop_cnt"}, dcnt, 0);
`endif
  endtask

  initial begin
    // 4-word packet: req held through ack, non-EOP tags, EOP tag without strobe, early rd
    add_v(1,0,2'b00,0,0, 1,0,1,11'h000, 0,11'h000, 15,0);
    add_v(1,1,2'b00,0,0, 0,0,0,11'h000, 0,11'h000, 15,0);
    add_v(0,1,2'b11,0,0, 0,0,0,11'h000, 0,11'h000, 15,0);
    add_v(0,0,2'b10,0,0, 0,0,0,11'h000, 0,11'h000, 15,0);
    add_v(0,1,2'b01,1,0, 0,0,0,11'h000, 0,11'h000, 15,0);
    add_v(0,1,2'b10,0,0, 0,0,0,11'h000, 0,11'h000, 15,1);
    add_v(0,0,2'b00,1,0, 0,0,0,11'h000, 1,11'h000, 15,0);
    add_v(0,0,2'b00,1,0, 0,0,0,11'h000, 0,11'h000, 15,0);
    add_v(0,0,2'b00,0,1, 0,0,0,11'h000, 0,11'h000, 16,0);
    // three back-to-back packets, push and pop together on the third EOP
    add_v(1,0,2'b00,0,0, 1,0,1,11'h000, 0,11'h000, 15,0);
    add_v(0,1,2'b10,0,0, 0,0,0,11'h000, 0,11'h000, 15,1);
    add_v(1,0,2'b00,0,0, 1,0,1,11'h080, 0,11'h000, 14,1);
    add_v(0,1,2'b10,0,0, 0,0,0,11'h000, 0,11'h000, 14,2);
    add_v(1,0,2'b00,0,0, 1,0,1,11'h100, 0,11'h000, 13,2);
    add_v(0,1,2'b10,1,0, 0,0,0,11'h000, 1,11'h000, 13,2);
    add_v(0,0,2'b00,0,1, 0,0,0,11'h000, 0,11'h000, 14,2);
    add_v(0,0,2'b00,1,0, 0,0,0,11'h000, 1,11'h080, 14,1);
    add_v(0,0,2'b00,0,1, 0,0,0,11'h000, 0,11'h000, 15,1);
    add_v(0,0,2'b00,1,0, 0,0,0,11'h000, 1,11'h100, 15,0);
    add_v(0,0,2'b00,0,1, 0,0,0,11'h000, 0,11'h000, 16,0);

    idle_inputs();
    rst_n = 1'b0;
    repeat (3) tick();
    chk_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk_reset_outputs("post-reset idle");

    foreach (vecs[i]) begin
      req = vecs[i].req; wr = vecs[i].wr; tag = vecs[i].tag;
      rd = vecs[i].rd; vwr = vecs[i].vwr;
      tick();
      chk($sformatf("v%0d ack", i), ack, vecs[i].ack);
      chk($sformatf("v%0d drop", i), drop, vecs[i].drop);
      chk($sformatf("v%0d waddr_wr", i), wwr, vecs[i].wwr);
      if (vecs[i].wwr) chk($sformatf("v%0d waddr", i), waddr, vecs[i].waddr);
      chk($sformatf("v%0d raddr_wr", i), rwr, vecs[i].rwr);
      if (vecs[i].rwr) chk($sformatf("v%0d raddr", i), raddr, vecs[i].raddr);
      chk($sformatf("v%0d free_cnt", i), fcnt, vecs[i].fcnt);
      chk($sformatf("v%0d queue_cnt", i), qcnt, vecs[i].qcnt);
    end
    idle_inputs();

    // Fill every slot, then a 17th request is dropped
    exp_free = 16;
    exp_q    = 0;
    for (int i = 0; i < 16; i++) alloc(i);
    chk("full free_cnt", fcnt, 0);
    req = 1'b1;
    tick();
    req = 1'b0;
    chk("full ack", ack, 0);
    chk("full drop", drop, 1);
    tick();
    chk("drop one-shot", drop, 0);
    chk("full queue_cnt", qcnt, 16);
`ifdef ADDR_MGMT_STAT_EN
    chk("drop_cnt after full", dcnt, 1);
`endif

    // Release of slot 0 in the same cycle as a request still drops
    rd = 1'b1;
    tick();
    rd = 1'b0;
    chk("race raddr", raddr, 11'h000);
    chk("race queue_cnt", qcnt, 15);
    req = 1'b1; vwr = 1'b1;
    tick();
    vwr = 1'b0;
    chk("race drop", drop, 1);
    chk("race ack", ack, 0);
    chk("race free_cnt", fcnt, 1);
    tick();
    req = 1'b0;
    chk("race retry ack", ack, 1);
    chk("race retry waddr", waddr, 11'h000);
    chk("race retry free_cnt", fcnt, 0);
    wr = 1'b1; tag = 2'b10;
    tick();
    wr = 1'b0; tag = 2'b00;
    chk("race queue_cnt full", qcnt, 16);
`ifdef ADDR_MGMT_STAT_EN
    chk("drop_cnt after race", dcnt, 2);
`endif

    // Enter W_FILL and R_BUSY together, then reset asynchronously
    rd = 1'b1;
    tick();
    rd = 1'b0;
    chk("pre-rst raddr", raddr, 11'h080);
    vwr = 1'b1;
    tick();
    vwr = 1'b0;
    req = 1'b1;
    tick();
    req = 1'b0;
    chk("pre-rst waddr", waddr, 11'h080);
    rd = 1'b1;
    tick();
    rd = 1'b0;
    chk("pre-rst raddr2", raddr, 11'h100);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("mid-op reset");
    @(negedge clk);
    rst_n = 1'b1;
    exp_free = 16;
    exp_q    = 0;
    alloc(0);
    rd_rel(0);

    // Arrange the queue so slot 5 is released before slot 2
    for (int i = 0; i < 6; i++) alloc(i);
    rd_rel(0); alloc(0);
    rd_rel(1); alloc(1);
    rd_rel(2); rd_rel(3);
    alloc(2); alloc(3);
    rd_rel(4); alloc(4);
    rd_rel(5);
    rd_rel(0); alloc(0);
    rd_rel(1); alloc(1);
    rd_rel(2);
    alloc(2);
    alloc(5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
